// File: rtl/max_latch_fifo.sv
// max_latch_fifo: captures the {position, value} peak of each scan line into a
// DEPTH-entry show-ahead FIFO with a valid/ready read port, and keeps a
// "last accepted peak" register alongside it.
// Optional feature macro: MAX_LATCH_THRESH_EN adds thr_val and only accepts
// strobes whose max_val >= thr_val (unsigned).
module max_latch_fifo #(
  parameter int POS_W = 9,
  parameter int VAL_W = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch,
  input  logic [POS_W-1:0] max_pos,
  input  logic [VAL_W-1:0] max_val,
`ifdef MAX_LATCH_THRESH_EN
  input  logic [VAL_W-1:0] thr_val,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [POS_W-1:0] max_pos_out,
  output logic [VAL_W-1:0] max_val_out,
  output logic [POS_W-1:0] last_pos,
  output logic [VAL_W-1:0] last_val,
  output logic [CW-1:0]    fill_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [POS_W-1:0] mem_pos [DEPTH];
  logic [VAL_W-1:0] mem_val [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [POS_W-1:0] last_pos_q, last_pos_d;
  logic [VAL_W-1:0] last_val_q, last_val_d;

  logic cap, full, pop, accept, drop;

  // Capture qualification, push/pop handshake decode.
  always_comb begin
`ifdef MAX_LATCH_THRESH_EN
    cap = latch & (max_val >= thr_val);
`else
    cap = latch;
`endif
    full   = (count_q == CW'(DEPTH));
    pop    = (count_q != '0) & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    accept = cap & (~full | pop);
    drop   = cap & full & ~pop;
  end

  // Next-state for pointers, fill count, sticky overflow and last-peak register.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    last_pos_d = last_pos_q;
    last_val_d = last_val_q;
    if (accept) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      last_pos_d = max_pos;
      last_val_d = max_val;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over clear.
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_pos_q <= '0;
      last_val_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_pos_q <= last_pos_d;
      last_val_q <= last_val_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_pos[wr_ptr_q] <= max_pos;
      mem_val[wr_ptr_q] <= max_val;
    end
  end

  // Show-ahead head presentation, masked to zero while empty.
  always_comb begin
    out_valid   = (count_q != '0);
    max_pos_out = out_valid ? mem_pos[rd_ptr_q] : '0;
    max_val_out = out_valid ? mem_val[rd_ptr_q] : '0;
    last_pos    = last_pos_q;
    last_val    = last_val_q;
    fill_count  = count_q;
    overflow    = overflow_q;
  end

endmodule
